// File: rtl/calc1_req_arbiter.sv
// rtl/calc1_req_arbiter.sv - round-robin front end sharing one calc1 ALU between four requesters
// Captures two-cycle requests per port, issues one ALU op at a time, routes results back.
module calc1_req_arbiter #(
  parameter int unsigned ALU_TIMEOUT = 15
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic [3:0]  req1_cmd_in,
  input  logic [31:0] req1_data_in,
  input  logic [3:0]  req2_cmd_in,
  input  logic [31:0] req2_data_in,
  input  logic [3:0]  req3_cmd_in,
  input  logic [31:0] req3_data_in,
  input  logic [3:0]  req4_cmd_in,
  input  logic [31:0] req4_data_in,
  output logic [1:0]  out_resp1,
  output logic [31:0] out_data1,
  output logic [1:0]  out_resp2,
  output logic [31:0] out_data2,
  output logic [1:0]  out_resp3,
  output logic [31:0] out_data3,
  output logic [1:0]  out_resp4,
  output logic [31:0] out_data4,
  output logic        alu_valid,
  output logic [3:0]  alu_cmd,
  output logic [31:0] alu_op1,
  output logic [31:0] alu_op2,
  input  logic        alu_done,
  input  logic [1:0]  alu_resp,
  input  logic [31:0] alu_data,
  output logic        protocol_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {SLOT_EMPTY, SLOT_CAPT, SLOT_PEND} slot_t;

  logic [3:0]  cmd_in  [4];
  logic [31:0] data_in [4];
  logic [1:0]  resp_o  [4];
  logic [31:0] data_o  [4];

  slot_t       slot_st  [4];
  logic [3:0]  slot_cmd [4];
  logic [31:0] slot_op1 [4];
  logic [31:0] slot_op2 [4];
  logic        slot_bad [4];
  logic        slot_free [4];
  logic        slot_take [4];

  state_t      state, state_nxt;
  logic [1:0]  ptr, grant, grant_nxt, pick, idx;
  logic        pend_any;
  logic [7:0]  cnt, cnt_nxt;
  logic [1:0]  rsp, rsp_nxt;
  logic [31:0] rdata, rdata_nxt;
  logic        perr;

  assign cmd_in[0]  = req1_cmd_in;
  assign cmd_in[1]  = req2_cmd_in;
  assign cmd_in[2]  = req3_cmd_in;
  assign cmd_in[3]  = req4_cmd_in;
  assign data_in[0] = req1_data_in;
  assign data_in[1] = req2_data_in;
  assign data_in[2] = req3_data_in;
  assign data_in[3] = req4_data_in;

  function automatic logic cmd_ok(input logic [3:0] c);
    return (c == 4'd1) || (c == 4'd2) || (c == 4'd5) || (c == 4'd6);
  endfunction

  // A slot being answered this cycle is free, so its port may start a new request now.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      slot_free[i] = (state == RESP) && (grant == 2'(i));
      slot_take[i] = (cmd_in[i] != 4'd0) && ((slot_st[i] == SLOT_EMPTY) || slot_free[i]);
    end
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        slot_st[i]  <= SLOT_EMPTY;
        slot_cmd[i] <= '0;
        slot_op1[i] <= '0;
        slot_op2[i] <= '0;
        slot_bad[i] <= 1'b0;
      end
      perr <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (slot_take[i]) begin
          slot_st[i]  <= SLOT_CAPT;
          slot_cmd[i] <= cmd_in[i];
          slot_op1[i] <= data_in[i];
          slot_bad[i] <= !cmd_ok(cmd_in[i]);
        end else if (slot_st[i] == SLOT_CAPT) begin
          slot_op2[i] <= data_in[i];
          slot_st[i]  <= SLOT_PEND;
        end else if (slot_free[i]) begin
          slot_st[i]  <= SLOT_EMPTY;
        end
        if ((cmd_in[i] != 4'd0) && (slot_st[i] == SLOT_PEND) && !slot_free[i])
          perr <= 1'b1;
      end
    end
  end

  always_comb begin
    pend_any = 1'b0;
    pick     = ptr;
    idx      = ptr;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!pend_any && (slot_st[idx] == SLOT_PEND)) begin
        pend_any = 1'b1;
        pick     = idx;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    cnt_nxt   = cnt;
    rsp_nxt   = rsp;
    rdata_nxt = rdata;
    case (state)
      IDLE: begin
        if (pend_any) begin
          grant_nxt = pick;
          if (slot_bad[pick]) begin
            rsp_nxt   = 2'd2;
            rdata_nxt = '0;
            state_nxt = RESP;
          end else begin
            state_nxt = ISSUE;
          end
        end
      end
      ISSUE: begin
        cnt_nxt   = '0;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (alu_done) begin
          rsp_nxt   = alu_resp;
          rdata_nxt = alu_data;
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt + 8'd1;
          if (cnt + 8'd1 == 8'(ALU_TIMEOUT)) begin
            rsp_nxt   = 2'd3;
            rdata_nxt = '0;
            state_nxt = RESP;
          end
        end
      end
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      grant <= '0;
      ptr   <= '0;
      cnt   <= '0;
      rsp   <= '0;
      rdata <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      cnt   <= cnt_nxt;
      rsp   <= rsp_nxt;
      rdata <= rdata_nxt;
      if (state == RESP)
        ptr <= grant + 2'd1;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      resp_o[i] = ((state == RESP) && (grant == 2'(i))) ? rsp : 2'd0;
      data_o[i] = ((state == RESP) && (grant == 2'(i))) ? rdata : 32'd0;
    end
  end

  assign alu_valid    = (state == ISSUE);
  assign alu_cmd      = (state == ISSUE) ? slot_cmd[grant] : 4'd0;
  assign alu_op1      = (state == ISSUE) ? slot_op1[grant] : 32'd0;
  assign alu_op2      = (state == ISSUE) ? slot_op2[grant] : 32'd0;
  assign protocol_err = perr;

  assign out_resp1 = resp_o[0];
  assign out_resp2 = resp_o[1];
  assign out_resp3 = resp_o[2];
  assign out_resp4 = resp_o[3];
  assign out_data1 = data_o[0];
  assign out_data2 = data_o[1];
  assign out_data3 = data_o[2];
  assign out_data4 = data_o[3];

endmodule

// File: tb/tb_calc1_req_arbiter.sv
// tb/tb_calc1_req_arbiter.sv - scoreboard bench for calc1_req_arbiter
// Directed requests push expected ALU issues and port responses; a monitor pops and compares.
module tb_calc1_req_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  rc [4];
  logic [31:0] rd [4];
  logic [1:0]  oresp [4];
  logic [31:0] odata [4];
  logic        alu_valid, alu_done, perr;
  logic [3:0]  alu_cmd;
  logic [31:0] alu_op1, alu_op2, alu_data;
  logic [1:0]  alu_resp;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int alu_lat = 1;
  bit alu_hang = 1'b0;
  bit inject = 1'b0;

  typedef struct {int port; logic [1:0] resp; logic [31:0] data; int cyc;} rsp_t;
  typedef struct {logic [3:0] cmd; logic [31:0] op1; logic [31:0] op2; int cyc;} iss_t;
  rsp_t rsp_q[$];
  iss_t iss_q[$];

  calc1_req_arbiter #(.ALU_TIMEOUT(15)) dut (
    .c_clk(clk), .reset(rst_n),
    .req1_cmd_in(rc[0]), .req1_data_in(rd[0]),
    .req2_cmd_in(rc[1]), .req2_data_in(rd[1]),
    .req3_cmd_in(rc[2]), .req3_data_in(rd[2]),
    .req4_cmd_in(rc[3]), .req4_data_in(rd[3]),
    .out_resp1(oresp[0]), .out_data1(odata[0]),
    .out_resp2(oresp[1]), .out_data2(odata[1]),
    .out_resp3(oresp[2]), .out_data3(odata[2]),
    .out_resp4(oresp[3]), .out_data4(odata[3]),
    .alu_valid(alu_valid), .alu_cmd(alu_cmd), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_done(alu_done), .alu_resp(alu_resp), .alu_data(alu_data),
    .protocol_err(perr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((iss_q.size() != 0 || rsp_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    chk("drain_pending", 64'(iss_q.size() + rsp_q.size()), 64'd0);
    step();
    step();
  endtask

  // Behavioural ALU: answers L cycles after the issue strobe unless hung.
  initial begin
    logic [3:0]  c;
    logic [31:0] a, b, r;
    alu_done = 1'b0; alu_resp = 2'd0; alu_data = 32'd0;
    forever begin
      @(negedge clk);
      if (inject) begin
        inject = 1'b0;
        @(posedge clk); #1;
        alu_done = 1'b1; alu_resp = 2'd1; alu_data = 32'hDEAD;
        @(posedge clk); #1;
        alu_done = 1'b0; alu_resp = 2'd0; alu_data = 32'd0;
      end else if (alu_valid && !alu_hang) begin
        c = alu_cmd; a = alu_op1; b = alu_op2;
        case (c)
          4'd1: r = a + b;
          4'd2: r = a - b;
          4'd5: r = a << b[4:0];
          default: r = a >> b[4:0];
        endcase
        repeat (alu_lat) @(posedge clk);
        #1;
        alu_done = 1'b1; alu_resp = 2'd1; alu_data = r;
        @(posedge clk); #1;
        alu_done = 1'b0; alu_resp = 2'd0; alu_data = 32'd0;
      end
    end
  end

  always @(negedge clk) begin
    int nz;
    rsp_t e;
    iss_t s;
    nz = 0;
    for (int p = 0; p < 4; p++) begin
      if (oresp[p] != 2'd0) begin
        nz++;
        n_vec++;
        if (rsp_q.size() == 0) begin
          n_err++;
          $display("FAIL resp_unexpected: port %0d resp %0d data %0h at cycle %0d", p + 1, oresp[p], odata[p], cyc);
        end else begin
          e = rsp_q.pop_front();
          if (p != e.port || oresp[p] !== e.resp || odata[p] !== e.data || cyc != e.cyc) begin
            n_err++;
            $display("FAIL resp: got port %0d resp %0d data %0h cycle %0d, expected port %0d resp %0d data %0h cycle %0d",
                     p + 1, oresp[p], odata[p], cyc, e.port + 1, e.resp, e.data, e.cyc);
          end
        end
      end
    end
    if (nz > 1) begin
      n_vec++;
      n_err++;
      $display("FAIL resp_multi: %0d ports responding at cycle %0d, expected 1", nz, cyc);
    end
    if (alu_valid) begin
      n_vec++;
      if (iss_q.size() == 0) begin
        n_err++;
        $display("FAIL issue_unexpected: cmd %0d op1 %0h op2 %0h at cycle %0d", alu_cmd, alu_op1, alu_op2, cyc);
      end else begin
        s = iss_q.pop_front();
        if (alu_cmd !== s.cmd || alu_op1 !== s.op1 || alu_op2 !== s.op2 || cyc != s.cyc) begin
          n_err++;
          $display("FAIL issue: got cmd %0d op1 %0h op2 %0h cycle %0d, expected cmd %0d op1 %0h op2 %0h cycle %0d",
                   alu_cmd, alu_op1, alu_op2, cyc, s.cmd, s.op1, s.op2, s.cyc);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk_quiet(input string tag);
    chk({tag, "_alu"}, {alu_valid, alu_cmd, alu_op1, alu_op2}, 64'd0);
    chk({tag, "_resp"}, 64'({oresp[0], oresp[1], oresp[2], oresp[3]}), 64'd0);
    chk({tag, "_data"}, 64'(odata[0] | odata[1] | odata[2] | odata[3]), 64'd0);
    chk({tag, "_perr"}, 64'(perr), 64'd0);
  endtask

  initial begin
    int t;
    rst_n = 1'b0;
    for (int p = 0; p < 4; p++) begin rc[p] = 4'd0; rd[p] = 32'd0; end
    step();
    step();
    chk_quiet("reset");
    rst_n = 1'b1;
    step();

    // all four ports subtract in the same cycle: served 1,2,3,4
    alu_lat = 1;
    t = cyc;
    for (int p = 0; p < 4; p++) begin
      rc[p] = 4'd2; rd[p] = 32'h10 + 32'(p);
      iss_q.push_back('{cmd: 4'd2, op1: 32'h10 + 32'(p), op2: 32'd1, cyc: t + 3 + 4 * p});
      rsp_q.push_back('{port: p, resp: 2'd1, data: 32'hF + 32'(p), cyc: t + 5 + 4 * p});
    end
    step();
    for (int p = 0; p < 4; p++) begin rc[p] = 4'd0; rd[p] = 32'd1; end
    step();
    for (int p = 0; p < 4; p++) rd[p] = 32'd0;
    drain(60);

    // ports 3 and 1 with pointer back at port 1
    t = cyc;
    rc[0] = 4'd1; rd[0] = 32'd7; rc[2] = 4'd5; rd[2] = 32'd3;
    iss_q.push_back('{cmd: 4'd1, op1: 32'd7, op2: 32'd9, cyc: t + 3});
    rsp_q.push_back('{port: 0, resp: 2'd1, data: 32'd16, cyc: t + 5});
    iss_q.push_back('{cmd: 4'd5, op1: 32'd3, op2: 32'd4, cyc: t + 7});
    rsp_q.push_back('{port: 2, resp: 2'd1, data: 32'h30, cyc: t + 9});
    step();
    rc[0] = 4'd0; rd[0] = 32'd9; rc[2] = 4'd0; rd[2] = 32'd4;
    step();
    rd[0] = 32'd0; rd[2] = 32'd0;
    drain(40);

    // invalid command answered locally
    t = cyc;
    rc[1] = 4'hF; rd[1] = 32'h1234;
    rsp_q.push_back('{port: 1, resp: 2'd2, data: 32'd0, cyc: t + 3});
    step();
    rc[1] = 4'd0; rd[1] = 32'h5678;
    step();
    rd[1] = 32'd0;
    drain(20);

    // single add, ALU latency 2
    alu_lat = 2;
    t = cyc;
    rc[0] = 4'd1; rd[0] = 32'd5;
    iss_q.push_back('{cmd: 4'd1, op1: 32'd5, op2: 32'd3, cyc: t + 3});
    rsp_q.push_back('{port: 0, resp: 2'd1, data: 32'd8, cyc: t + 6});
    step();
    rc[0] = 4'd0; rd[0] = 32'd3;
    step();
    rd[0] = 32'd0;
    drain(20);

    // hung ALU: port 4 then port 1 both time out 16 cycles after issue
    alu_hang = 1'b1;
    t = cyc;
    rc[3] = 4'd1; rd[3] = 32'd1; rc[0] = 4'd2; rd[0] = 32'd6;
    iss_q.push_back('{cmd: 4'd1, op1: 32'd1, op2: 32'd1, cyc: t + 3});
    rsp_q.push_back('{port: 3, resp: 2'd3, data: 32'd0, cyc: t + 19});
    iss_q.push_back('{cmd: 4'd2, op1: 32'd6, op2: 32'd2, cyc: t + 21});
    rsp_q.push_back('{port: 0, resp: 2'd3, data: 32'd0, cyc: t + 37});
    step();
    rc[3] = 4'd0; rd[3] = 32'd1; rc[0] = 4'd0; rd[0] = 32'd2;
    step();
    rd[3] = 32'd0; rd[0] = 32'd0;
    drain(80);
    alu_hang = 1'b0;

    // second command while pending is dropped and flags protocol_err
    alu_lat = 1;
    t = cyc;
    rc[0] = 4'd1; rd[0] = 32'd2;
    iss_q.push_back('{cmd: 4'd1, op1: 32'd2, op2: 32'd3, cyc: t + 3});
    rsp_q.push_back('{port: 0, resp: 2'd1, data: 32'd5, cyc: t + 5});
    step();
    rc[0] = 4'd0; rd[0] = 32'd3;
    chk("perr_before", 64'(perr), 64'd0);
    step();
    rc[0] = 4'd2; rd[0] = 32'h99;
    step();
    rc[0] = 4'd0; rd[0] = 32'h77;
    chk("perr_set", 64'(perr), 64'd1);
    step();
    rd[0] = 32'd0;
    drain(20);
    chk("perr_sticky", 64'(perr), 64'd1);

    // reset during WAIT with other ports pending
    alu_hang = 1'b1;
    t = cyc;
    for (int p = 0; p < 3; p++) begin rc[p] = 4'd1; rd[p] = 32'h40 + 32'(p); end
    iss_q.push_back('{cmd: 4'd1, op1: 32'h41, op2: 32'h51, cyc: t + 3});
    step();
    for (int p = 0; p < 3; p++) begin rc[p] = 4'd0; rd[p] = 32'h50 + 32'(p); end
    step();
    for (int p = 0; p < 3; p++) rd[p] = 32'd0;
    step(); step(); step();
    rst_n = 1'b0;
    #1;
    chk_quiet("midreset");
    step();
    step();
    rst_n = 1'b1;
    inject = 1'b1;
    repeat (8) step();
    chk("late_done_queue", 64'(iss_q.size() + rsp_q.size()), 64'd0);
    chk_quiet("after_reset");

    alu_hang = 1'b0;
    t = cyc;
    rc[2] = 4'd6; rd[2] = 32'h80; rc[0] = 4'd1; rd[0] = 32'h11;
    iss_q.push_back('{cmd: 4'd1, op1: 32'h11, op2: 32'h22, cyc: t + 3});
    rsp_q.push_back('{port: 0, resp: 2'd1, data: 32'h33, cyc: t + 5});
    iss_q.push_back('{cmd: 4'd6, op1: 32'h80, op2: 32'd3, cyc: t + 7});
    rsp_q.push_back('{port: 2, resp: 2'd1, data: 32'h10, cyc: t + 9});
    step();
    rc[2] = 4'd0; rd[2] = 32'd3; rc[0] = 4'd0; rd[0] = 32'h22;
    step();
    rd[2] = 32'd0; rd[0] = 32'd0;
    drain(40);
    chk("perr_final", 64'(perr), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
